// File: rtl/ps2_byte_receiver_if.sv
// Result bus of the PS/2 byte receiver: held byte, one-cycle result strobes and busy flag.
interface ps2_byte_receiver_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       PARITY_ERR;
  logic       FRAME_ERR;
  logic       BUSY;

  modport master (output DATA, output VALID, output PARITY_ERR, output FRAME_ERR, output BUSY);
  modport slave  (input  DATA, input  VALID, input  PARITY_ERR, input  FRAME_ERR, input  BUSY);
endinterface

// File: rtl/ps2_byte_receiver.sv
// Receive-only PS/2 deserializer: synchronizes and filters PS2_CLK/PS2_DAT, captures
// 11-bit frames and reports each one as a good byte, a parity error or a framing error.
module ps2_byte_receiver #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic                 PS2_CLK,
  input  logic                 PS2_DAT,
  ps2_byte_receiver_if.master  o_rx
);

  localparam int unsigned FLT_W    = 8;
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W    = 4;
  localparam int unsigned SHIFT_W  = 10;
  localparam int unsigned LAST_BIT = 11;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK} state_t;

  logic [1:0]       r_clk_sync;
  logic [1:0]       r_dat_sync;
  logic [FLT_W-1:0] r_flt_cnt;
  logic             r_fclk;
  logic             r_fall;
  logic             w_dat;

  // Synchronizers plus level filter; r_fall marks the cycle fclk drops to 0.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_flt_cnt  <= '0;
      r_fclk     <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DAT};
      r_fall     <= 1'b0;
      if (r_clk_sync[1] == r_fclk) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        r_fclk    <= ~r_fclk;
        r_flt_cnt <= '0;
        r_fall    <= r_fclk;
      end else begin
        r_flt_cnt <= r_flt_cnt + FLT_W'(1);
      end
    end
  end

  assign w_dat = r_dat_sync[1];

  state_t             r_state,   w_state_nx;
  logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_nx;
  logic [TO_W-1:0]    r_to_cnt,  w_to_cnt_nx;
  logic [SHIFT_W-1:0] r_shift,   w_shift_nx;
  logic [7:0]         r_data,    w_data_nx;
  logic               r_valid,   w_valid_nx;
  logic               r_perr,    w_perr_nx;
  logic               r_ferr,    w_ferr_nx;
  logic               r_busy,    w_busy_nx;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_to_cnt  <= w_to_cnt_nx;
      r_shift   <= w_shift_nx;
      r_data    <= w_data_nx;
      r_valid   <= w_valid_nx;
      r_perr    <= w_perr_nx;
      r_ferr    <= w_ferr_nx;
      r_busy    <= w_busy_nx;
    end
  end

  // The start bit is known to be 0, so only data, parity and stop are shifted in
  // (LSB-first from the top): after the stop bit, [7:0]=data, [8]=parity, [9]=stop.
  always_comb begin
    w_state_nx   = r_state;
    w_bit_cnt_nx = r_bit_cnt;
    w_to_cnt_nx  = r_to_cnt;
    w_shift_nx   = r_shift;
    w_data_nx    = r_data;
    w_valid_nx   = 1'b0;
    w_perr_nx    = 1'b0;
    w_ferr_nx    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_fall && !w_dat) begin
          w_state_nx   = S_RECV;
          w_bit_cnt_nx = BIT_W'(1);
          w_to_cnt_nx  = '0;
        end
      end
      S_RECV: begin
        if (r_fall) begin
          w_shift_nx   = {w_dat, r_shift[SHIFT_W-1:1]};
          w_bit_cnt_nx = r_bit_cnt + BIT_W'(1);
          w_to_cnt_nx  = '0;
          if (r_bit_cnt == BIT_W'(LAST_BIT - 1)) w_state_nx = S_CHECK;
        end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_ferr_nx   = 1'b1;
          w_to_cnt_nx = '0;
          w_state_nx  = S_IDLE;
        end else begin
          w_to_cnt_nx = r_to_cnt + TO_W'(1);
        end
      end
      S_CHECK: begin
        w_state_nx = S_IDLE;
        if (!r_shift[9]) begin
          w_ferr_nx = 1'b1;
        end else if ((^r_shift[8:0]) == 1'b0) begin
          w_perr_nx = 1'b1;
        end else begin
          w_valid_nx = 1'b1;
          w_data_nx  = r_shift[7:0];
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE);
  end

  assign o_rx.DATA       = r_data;
  assign o_rx.VALID      = r_valid;
  assign o_rx.PARITY_ERR = r_perr;
  assign o_rx.FRAME_ERR  = r_ferr;
  assign o_rx.BUSY       = r_busy;

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Bench for ps2_byte_receiver: drives PS/2 frames on the pins and compares every result
// pulse against a frame-level model of the receive rules.
module tb_ps2_byte_receiver;

  localparam int unsigned FL = 8;
  localparam int unsigned TO = 400;
  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_PERR  = 3'b010;
  localparam logic [2:0] K_FERR  = 3'b100;

  logic clk, rst, ps2_clk, ps2_dat;

  ps2_byte_receiver_if rx();

  ps2_byte_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat),
    .o_rx     (rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    logic       busy;
    int         cyc;
  } ev_t;

  ev_t evq[$];
  ev_t mon_e;

  // Every cycle with any result strobe is logged with the strobes seen together.
  always @(negedge clk) begin
    if (rx.VALID || rx.PARITY_ERR || rx.FRAME_ERR) begin
      mon_e.kind = {rx.FRAME_ERR, rx.PARITY_ERR, rx.VALID};
      mon_e.data = rx.DATA;
      mon_e.busy = rx.BUSY;
      mon_e.cyc  = cyc;
      evq.push_back(mon_e);
    end
  end

  int checks = 0;
  int failures = 0;
  int hp = 40;
  logic [7:0] model_data = 8'h00;

  // Outcome of a complete frame according to the receive rules.
  function automatic logic [2:0] model_kind(input logic [7:0] b, input logic par, input logic stop);
    if (!stop) return K_FERR;
    if ((^{b, par}) == 1'b0) return K_PERR;
    return K_VALID;
  endfunction

  function automatic logic odd_par(input logic [7:0] b);
    return ~(^b);
  endfunction

  task automatic hold_phase(input logic lvl, input bit glitch);
    int g;
    ps2_clk = lvl;
    if (glitch) begin
      g = $urandom_range(12, hp - 6);
      repeat (g) @(negedge clk);
      ps2_clk = ~lvl;
      repeat (3) @(negedge clk);
      ps2_clk = lvl;
      repeat (hp - g - 3) @(negedge clk);
    end else begin
      repeat (hp) @(negedge clk);
    end
  endtask

  // Sends the first nbits of a frame; t_last is the cycle of the last pin falling edge.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int nbits, input bit glitch, output int t_last);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    t_last = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      hold_phase(1'b1, glitch);
      t_last = cyc;
      hold_phase(1'b0, glitch);
    end
    ps2_clk = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rx.DATA !== 8'h00) begin failures++; $display("FAIL reset_data: got %0h expected 00", rx.DATA); end
    checks++; if ({rx.FRAME_ERR, rx.PARITY_ERR, rx.VALID} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b expected 000", {rx.FRAME_ERR, rx.PARITY_ERR, rx.VALID}); end
    checks++; if (rx.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", rx.BUSY); end
    checks++; if (evq.size() != 0) begin failures++; $display("FAIL reset_events: got %0d pulses expected 0", evq.size()); end
    evq.delete();
  endtask

  task automatic test_clean();
    int t; ev_t e;
    hp = 40;
    send_frame(8'h75, 1'b0, 1'b1, 11, 1'b0, t);
    model_data = 8'h75;
    checks++;
    if (evq.size() == 0) begin
      failures++; $display("FAIL clean_pulse: got none expected VALID");
    end else begin
      e = evq.pop_front();
      checks++; if (e.kind !== K_VALID) begin failures++; $display("FAIL clean_kind: got %b expected %b", e.kind, K_VALID); end
      checks++; if (e.data !== 8'h75) begin failures++; $display("FAIL clean_data: got %0h expected 75", e.data); end
      checks++; if (e.busy !== 1'b0) begin failures++; $display("FAIL clean_busy_at_pulse: got %b expected 0", e.busy); end
      checks++; if (e.cyc - t < int'(FL) + 3 || e.cyc - t > int'(FL) + 6) begin failures++; $display("FAIL clean_latency: got %0d expected %0d..%0d", e.cyc - t, FL + 3, FL + 6); end
    end
    checks++; if (evq.size() != 0) begin failures++; $display("FAIL clean_extra: got %0d extra pulses expected 0", evq.size()); end
    checks++; if (rx.BUSY !== 1'b0) begin failures++; $display("FAIL clean_busy_end: got %b expected 0", rx.BUSY); end
    evq.delete();
  endtask

  task automatic test_back_to_back();
    int t; ev_t e;
    logic [7:0] exp_d [2];
    exp_d[0] = 8'hF0;
    exp_d[1] = 8'h75;
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, t);
    checks++; if (rx.DATA !== 8'hF0) begin failures++; $display("FAIL b2b_hold: got %0h expected f0", rx.DATA); end
    send_frame(8'h75, 1'b0, 1'b1, 11, 1'b0, t);
    model_data = 8'h75;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (evq.size() == 0) begin
        failures++; $display("FAIL b2b_pulse%0d: got none expected VALID", i);
      end else begin
        e = evq.pop_front();
        checks++; if (e.kind !== K_VALID || e.data !== exp_d[i]) begin failures++; $display("FAIL b2b_frame%0d: got kind %b data %0h expected kind %b data %0h", i, e.kind, e.data, K_VALID, exp_d[i]); end
      end
    end
    checks++; if (evq.size() != 0) begin failures++; $display("FAIL b2b_extra: got %0d extra pulses expected 0", evq.size()); end
    evq.delete();
  endtask

  task automatic test_parity();
    int t; ev_t e;
    logic [2:0] exp_k [2];
    exp_k[0] = K_VALID;
    exp_k[1] = K_PERR;
    send_frame(8'h6B, 1'b0, 1'b1, 11, 1'b0, t);
    send_frame(8'h72, 1'b0, 1'b1, 11, 1'b0, t);
    model_data = 8'h6B;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (evq.size() == 0) begin
        failures++; $display("FAIL parity_pulse%0d: got none expected %b", i, exp_k[i]);
      end else begin
        e = evq.pop_front();
        checks++; if (e.kind !== exp_k[i] || e.data !== 8'h6B) begin failures++; $display("FAIL parity_frame%0d: got kind %b data %0h expected kind %b data 6b", i, e.kind, e.data, exp_k[i]); end
      end
    end
    checks++; if (rx.DATA !== 8'h6B) begin failures++; $display("FAIL parity_data_kept: got %0h expected 6b", rx.DATA); end
    evq.delete();
  endtask

  task automatic test_stop_bit();
    int t; ev_t e;
    send_frame(8'h74, 1'b1, 1'b0, 11, 1'b0, t);
    checks++;
    if (evq.size() == 0) begin
      failures++; $display("FAIL stop_pulse: got none expected FRAME_ERR");
    end else begin
      e = evq.pop_front();
      checks++; if (e.kind !== K_FERR) begin failures++; $display("FAIL stop_kind: got %b expected %b", e.kind, K_FERR); end
    end
    checks++; if (rx.DATA !== model_data) begin failures++; $display("FAIL stop_data_kept: got %0h expected %0h", rx.DATA, model_data); end
    evq.delete();
  endtask

  task automatic test_timeout();
    int t; ev_t e;
    send_frame(8'h0F, 1'b1, 1'b1, 5, 1'b0, t);
    checks++; if (rx.BUSY !== 1'b1) begin failures++; $display("FAIL timeout_busy_mid: got %b expected 1", rx.BUSY); end
    checks++; if (evq.size() != 0) begin failures++; $display("FAIL timeout_early: got %0d pulses expected 0", evq.size()); end
    evq.delete();
    repeat (TO + FL + 20) @(negedge clk);
    checks++;
    if (evq.size() == 0) begin
      failures++; $display("FAIL timeout_pulse: got none expected FRAME_ERR");
    end else begin
      e = evq.pop_front();
      checks++; if (e.kind !== K_FERR) begin failures++; $display("FAIL timeout_kind: got %b expected %b", e.kind, K_FERR); end
      checks++; if (e.cyc - t < int'(TO + FL) + 1 || e.cyc - t > int'(TO + FL) + 5) begin failures++; $display("FAIL timeout_latency: got %0d expected %0d..%0d", e.cyc - t, TO + FL + 1, TO + FL + 5); end
      checks++; if (e.busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b expected 0", e.busy); end
    end
    evq.delete();
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b0, t);
    model_data = 8'h5A;
    checks++;
    if (evq.size() == 0) begin
      failures++; $display("FAIL timeout_next_pulse: got none expected VALID");
    end else begin
      e = evq.pop_front();
      checks++; if (e.kind !== K_VALID || e.data !== 8'h5A) begin failures++; $display("FAIL timeout_next: got kind %b data %0h expected kind %b data 5a", e.kind, e.data, K_VALID); end
    end
    evq.delete();
  endtask

  task automatic test_glitch_reset();
    int t; ev_t e;
    send_frame(8'h79, 1'b0, 1'b1, 11, 1'b1, t);
    checks++;
    if (evq.size() == 0) begin
      failures++; $display("FAIL glitch_pulse: got none expected VALID");
    end else begin
      e = evq.pop_front();
      checks++; if (e.kind !== K_VALID || e.data !== 8'h79) begin failures++; $display("FAIL glitch_frame: got kind %b data %0h expected kind %b data 79", e.kind, e.data, K_VALID); end
    end
    checks++; if (evq.size() != 0) begin failures++; $display("FAIL glitch_extra: got %0d extra pulses expected 0", evq.size()); end
    evq.delete();
    send_frame(8'h79, 1'b0, 1'b1, 7, 1'b0, t);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_data = 8'h00;
    repeat (TO + 100) @(negedge clk);
    checks++; if (evq.size() != 0) begin failures++; $display("FAIL midreset_pulses: got %0d pulses expected 0", evq.size()); end
    checks++; if (rx.DATA !== 8'h00) begin failures++; $display("FAIL midreset_data: got %0h expected 00", rx.DATA); end
    checks++; if (rx.BUSY !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", rx.BUSY); end
    evq.delete();
    send_frame(8'h79, 1'b0, 1'b1, 11, 1'b0, t);
    model_data = 8'h79;
    checks++;
    if (evq.size() == 0) begin
      failures++; $display("FAIL after_reset_pulse: got none expected VALID");
    end else begin
      e = evq.pop_front();
      checks++; if (e.kind !== K_VALID || e.data !== 8'h79) begin failures++; $display("FAIL after_reset_frame: got kind %b data %0h expected kind %b data 79", e.kind, e.data, K_VALID); end
    end
    evq.delete();
  endtask

  task automatic test_random();
    int t; int r; ev_t e;
    logic [7:0] b; logic par, stop; logic [2:0] k; bit gl;
    for (int n = 0; n < 20; n++) begin
      hp   = $urandom_range(30, 50);
      b    = 8'($urandom);
      r    = $urandom_range(0, 9);
      par  = (r == 8) ? ~odd_par(b) : odd_par(b);
      stop = (r == 9) ? 1'b0 : 1'b1;
      gl   = 1'($urandom_range(0, 1));
      send_frame(b, par, stop, 11, gl, t);
      k = model_kind(b, par, stop);
      if (k == K_VALID) model_data = b;
      checks++;
      if (evq.size() == 0) begin
        failures++; $display("FAIL rand%0d_pulse: got none expected %b", n, k);
      end else begin
        e = evq.pop_front();
        checks++; if (e.kind !== k) begin failures++; $display("FAIL rand%0d_kind: byte %0h par %b stop %b got %b expected %b", n, b, par, stop, e.kind, k); end
        checks++; if (e.data !== model_data) begin failures++; $display("FAIL rand%0d_data: got %0h expected %0h", n, e.data, model_data); end
        checks++; if (e.cyc - t < int'(FL) + 3 || e.cyc - t > int'(FL) + 6) begin failures++; $display("FAIL rand%0d_latency: got %0d expected %0d..%0d", n, e.cyc - t, FL + 3, FL + 6); end
        checks++; if (e.busy !== 1'b0) begin failures++; $display("FAIL rand%0d_busy: got %b expected 0", n, e.busy); end
      end
      checks++; if (evq.size() != 0) begin failures++; $display("FAIL rand%0d_extra: got %0d extra pulses expected 0", n, evq.size()); end
      evq.delete();
    end
    hp = 40;
  endtask

  initial begin
    rst     = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    test_reset();
    test_clean();
    test_back_to_back();
    test_parity();
    test_stop_bit();
    test_timeout();
    test_glitch_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
